// File: rtl/gigatron_pkg.sv
// Shared encodings, condition codes and helpers for the Gigatron-compatible core.
package gigatron_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [2:0] {
    OP_LD  = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_ST  = 3'd6,
    OP_BCC = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    MODE_D_AC    = 3'd0,
    MODE_X_AC    = 3'd1,
    MODE_YD_AC   = 3'd2,
    MODE_YX_AC   = 3'd3,
    MODE_D_X     = 3'd4,
    MODE_D_Y     = 3'd5,
    MODE_D_OUT   = 3'd6,
    MODE_YXI_OUT = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    BUS_D   = 2'd0,
    BUS_RAM = 2'd1,
    BUS_AC  = 2'd2,
    BUS_IN  = 2'd3
  } bus_e;

  localparam logic [2:0] CC_FAR = 3'd0;
  localparam logic [2:0] CC_GT  = 3'd1;
  localparam logic [2:0] CC_LT  = 3'd2;
  localparam logic [2:0] CC_NE  = 3'd3;
  localparam logic [2:0] CC_EQ  = 3'd4;
  localparam logic [2:0] CC_GE  = 3'd5;
  localparam logic [2:0] CC_LE  = 3'd6;
  localparam logic [2:0] CC_BRA = 3'd7;

  localparam int unsigned OUT_VSYNC = 7;
  localparam int unsigned OUT_HSYNC = 6;

  typedef struct packed {
    op_e               op;
    mode_e             mode;
    bus_e              bus;
    logic [DATA_W-1:0] d;
  } instr_t;

  // Branch condition on the accumulator; the far jump is decided by the caller.
  function automatic logic cond_met(input logic [2:0] cc, input logic [DATA_W-1:0] ac);
    logic zero;
    logic neg;
    zero = (ac == '0);
    neg  = ac[DATA_W-1];
    case (cc)
      CC_GT:   cond_met = !neg && !zero;
      CC_LT:   cond_met = neg;
      CC_NE:   cond_met = !zero;
      CC_EQ:   cond_met = zero;
      CC_GE:   cond_met = !neg;
      CC_LE:   cond_met = neg || zero;
      CC_BRA:  cond_met = 1'b1;
      default: cond_met = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/gigatron_ram.sv
// Data RAM: asynchronous read, synchronous write, contents survive reset.
module gigatron_ram
  import gigatron_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/gigatron_cpu.sv
// Gigatron-compatible CPU core: fetch/execute pipeline over a synchronous external ROM,
// internal data RAM, OUT/XOUT registers and a synchronised input port.
module gigatron_cpu
  import gigatron_pkg::*;
#(
  parameter int unsigned ROM_AW         = 10,
  parameter int unsigned RAM_AW         = 10,
  parameter bit          DELAYED_BRANCH = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [DATA_W-1:0]  in_port,
  output logic [DATA_W-1:0]  out_reg,
  output logic [DATA_W-1:0]  xout,
  output logic [PC_W-1:0]    pc_dbg,
  output logic [DATA_W-1:0]  ac_dbg
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]  ac_q, ac_d;
  logic [DATA_W-1:0]  x_q, x_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic [DATA_W-1:0]  xout_q, xout_d;
  logic [DATA_W-1:0]  in_s1_q, in_s2_q;
  logic               slot_valid_q, slot_valid_d;
  logic               fresh_q;
  logic [INSTR_W-1:0] hold_q;

  instr_t             instr;
  logic [RAM_AW-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DATA_W-1:0]  bus;
  logic [DATA_W-1:0]  alu;
  logic               ram_we;
  logic               taken;
  logic               out_wr;

  // While stalled the ROM keeps reading the next address, so the pending word is parked.
  assign instr = instr_t'(fresh_q ? rom_data : hold_q);

  // Effective RAM address, truncated to the RAM width.
  always_comb begin
    ram_addr = RAM_AW'(instr.d);
    if (instr.op != OP_BCC) begin
      case (instr.mode)
        MODE_X_AC:                ram_addr = RAM_AW'(x_q);
        MODE_YD_AC:               ram_addr = RAM_AW'({y_q, instr.d});
        MODE_YX_AC, MODE_YXI_OUT: ram_addr = RAM_AW'({y_q, x_q});
        default:                  ram_addr = RAM_AW'(instr.d);
      endcase
    end
  end

  // Bus source and ALU.
  always_comb begin
    bus = instr.d;
    case (instr.bus)
      BUS_D:   bus = instr.d;
      BUS_RAM: bus = ram_rdata;
      BUS_AC:  bus = ac_q;
      default: bus = in_s2_q;
    endcase
    alu = bus;
    case (instr.op)
      OP_AND:  alu = ac_q & bus;
      OP_OR:   alu = ac_q | bus;
      OP_XOR:  alu = ac_q ^ bus;
      OP_ADD:  alu = ac_q + bus;
      OP_SUB:  alu = ac_q - bus;
      default: alu = bus;
    endcase
  end

  // Execute stage: next register state, RAM write and branch resolution.
  always_comb begin
    pc_d         = pc_q + PC_W'(1);
    ac_d         = ac_q;
    x_d          = x_q;
    y_d          = y_q;
    out_d        = out_q;
    xout_d       = xout_q;
    slot_valid_d = 1'b1;
    ram_we       = 1'b0;
    taken        = 1'b0;
    out_wr       = 1'b0;
    if (slot_valid_q) begin
      if (instr.op == OP_BCC) begin
        if (3'(instr.mode) == CC_FAR) begin
          taken = 1'b1;
          pc_d  = {y_q, bus};
        end else if (cond_met(3'(instr.mode), ac_q)) begin
          taken = 1'b1;
          pc_d  = {pc_q[PC_W-1:DATA_W], bus};
        end
      end else begin
        if (instr.op == OP_ST) begin
          ram_we = (instr.bus != BUS_RAM);
        end else begin
          case (instr.mode)
            MODE_D_X:                 x_d = alu;
            MODE_D_Y:                 y_d = alu;
            MODE_D_OUT, MODE_YXI_OUT: begin
              out_d  = alu;
              out_wr = 1'b1;
            end
            default:                  ac_d = alu;
          endcase
        end
        if (instr.mode == MODE_YXI_OUT) begin
          x_d = x_q + DATA_W'(1);
        end
      end
    end
    if (taken && !DELAYED_BRANCH) begin
      slot_valid_d = 1'b0;
    end
    // XOUT latches the pre-instruction AC on the rising edge of hsync.
    if (out_wr && !out_q[OUT_HSYNC] && out_d[OUT_HSYNC]) begin
      xout_d = ac_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q         <= '0;
      ac_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      out_q        <= '0;
      xout_q       <= '0;
      in_s1_q      <= '0;
      in_s2_q      <= '0;
      slot_valid_q <= 1'b0;
      fresh_q      <= 1'b1;
      hold_q       <= '0;
    end else begin
      fresh_q <= run;
      if (run) begin
        pc_q         <= pc_d;
        ac_q         <= ac_d;
        x_q          <= x_d;
        y_q          <= y_d;
        out_q        <= out_d;
        xout_q       <= xout_d;
        in_s1_q      <= in_port;
        in_s2_q      <= in_s1_q;
        slot_valid_q <= slot_valid_d;
      end else if (fresh_q) begin
        hold_q <= rom_data;
      end
    end
  end

  gigatron_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clock  (clock),
    .we_i   (ram_we && run && reset),
    .addr_i (ram_addr),
    .wdata_i(bus),
    .rdata_c(ram_rdata)
  );

  assign rom_addr = ROM_AW'(pc_q);
  assign out_reg  = out_q;
  assign xout     = xout_q;
  assign pc_dbg   = pc_q;
  assign ac_dbg   = ac_q;

endmodule

// File: tb/tb_gigatron_cpu.sv
// Scoreboard bench: two cores (delay slot on/off) share one ROM image; directed programs
// queue cycle-stamped expectations that a negedge monitor compares and retires.
module tb_gigatron_cpu;

  localparam int unsigned ROM_AW = 10;
  localparam int unsigned RAM_AW = 10;
  localparam int S_PC = 0, S_AC = 1, S_OUT = 2, S_XOUT = 3, S_X = 4, S_Y = 5, D0 = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset = 1'b0;
  logic              run = 1'b1;
  logic [7:0]        in_port = 8'hC3;
  logic [15:0]       rom [0:(1<<ROM_AW)-1];
  logic [ROM_AW-1:0] rom_addr1, rom_addr0;
  logic [15:0]       rom_data1, rom_data0;
  logic [7:0]        out_reg1, out_reg0, xout1, xout0, ac_dbg1, ac_dbg0;
  logic [15:0]       pc_dbg1, pc_dbg0;

  always @(posedge clock) begin
    rom_data1 <= rom[rom_addr1];
    rom_data0 <= rom[rom_addr0];
  end

  gigatron_cpu #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .DELAYED_BRANCH(1'b1)) u_db1 (
    .clock(clock), .reset(reset), .run(run), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .in_port(in_port), .out_reg(out_reg1), .xout(xout1), .pc_dbg(pc_dbg1), .ac_dbg(ac_dbg1));

  gigatron_cpu #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .DELAYED_BRANCH(1'b0)) u_db0 (
    .clock(clock), .reset(reset), .run(run), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .in_port(in_port), .out_reg(out_reg0), .xout(xout0), .pc_dbg(pc_dbg0), .ac_dbg(ac_dbg0));

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_dchecks = 0;
  int   n_dpass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] probe(input int sig);
    case (sig)
      S_PC:        return pc_dbg1;
      S_AC:        return {8'h00, ac_dbg1};
      S_OUT:       return {8'h00, out_reg1};
      S_XOUT:      return {8'h00, xout1};
      S_X:         return {8'h00, u_db1.x_q};
      S_Y:         return {8'h00, u_db1.y_q};
      D0 + S_PC:   return pc_dbg0;
      D0 + S_AC:   return {8'h00, ac_dbg0};
      D0 + S_OUT:  return {8'h00, out_reg0};
      D0 + S_XOUT: return {8'h00, xout0};
      D0 + S_X:    return {8'h00, u_db0.x_q};
      D0 + S_Y:    return {8'h00, u_db0.y_q};
      default:     return 16'hxxxx;
    endcase
  endfunction

  // Monitor: retire every expectation due by this cycle; late ones count as failures.
  always @(negedge clock) begin
    int nc;
    int np;
    logic [15:0] act;
    nc = 0;
    np = 0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = probe(sb[i].sig);
        nc++;
        if (sb[i].cyc == cyc && act === sb[i].val) np++;
        else $display("FAIL %s: got %h want %h (cycle %0d, due %0d)",
                      sb[i].name, act, sb[i].val, cyc, sb[i].cyc);
        sb.delete(i);
      end
    end
    n_checks <= n_checks + nc;
    n_pass   <= n_pass + np;
  end

  function automatic void exp1(input int k, input int sig, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc  = base + k;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  function automatic void exp2(input int k, input int sig, input logic [15:0] v, input string nm);
    exp1(k, sig, v, {nm, "_db1"});
    exp1(k, sig + D0, v, {nm, "_db0"});
  endfunction

  // Immediate comparison of a sampled value.
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_dchecks++;
    if (act === want) n_dpass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Bounded wait for a core's PC to reach a value; an expired wait is a failure.
  task automatic wait_pc(input string nm, input int sig, input logic [15:0] want, input int max_cyc);
    int k;
    k = 0;
    while (probe(sig) !== want && k < max_cyc) begin
      tick(1);
      k++;
    end
    n_dchecks++;
    if (probe(sig) === want) n_dpass++;
    else $display("FAIL %s: wait for pc %h expired after %0d cycles (cycle %0d)",
                  nm, want, max_cyc, cyc);
  endtask

  task automatic load_nops();
    for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 16'h0200;
  endtask

  // Leaves the bench inside release cycle c0, with base marking it.
  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b1;
    tick(2);
    reset = 1'b1;
    base  = cyc;
  endtask

  initial begin
    // Reset state and first-instruction latency.
    reset = 1'b0;
    load_nops();
    rom[0] = 16'h005A;                     // LD $5A
    do_reset();
    chk("rst_now_pc_db1", pc_dbg1, 16'h0000);
    chk("rst_now_ac_db1", {8'h00, ac_dbg1}, 16'h0000);
    chk("rst_now_out_db1", {8'h00, out_reg1}, 16'h0000);
    chk("rst_now_xout_db1", {8'h00, xout1}, 16'h0000);
    chk("rst_now_pc_db0", pc_dbg0, 16'h0000);
    chk("rst_now_ac_db0", {8'h00, ac_dbg0}, 16'h0000);
    chk("rst_now_out_db0", {8'h00, out_reg0}, 16'h0000);
    chk("rst_now_xout_db0", {8'h00, xout0}, 16'h0000);
    exp2(0, S_PC, 16'h0000, "rst_pc");
    exp2(0, S_AC, 16'h0000, "rst_ac");
    exp2(0, S_OUT, 16'h0000, "rst_out");
    exp2(0, S_XOUT, 16'h0000, "rst_xout");
    exp2(1, S_PC, 16'h0001, "pc_c1");
    exp2(1, S_AC, 16'h0000, "ac_c1");
    exp2(2, S_PC, 16'h0002, "pc_c2");
    exp2(2, S_AC, 16'h005A, "ac_c2");
    tick(5);

    // ALU wrap and conditional branches on AC = 0xFE.
    reset = 1'b0;
    load_nops();
    rom[0]  = 16'h00FF;                    // LD $FF
    rom[1]  = 16'h8002;                    // ADD $02
    rom[2]  = 16'hA003;                    // SUB $03
    rom[3]  = 16'hE808;                    // BLT $08
    rom[8]  = 16'hF420;                    // BGE $20
    rom[9]  = 16'hE420;                    // BGT $20
    rom[10] = 16'h0007;                    // LD $07
    do_reset();
    exp2(2, S_AC, 16'h00FF, "ld_ff");
    exp2(3, S_AC, 16'h0001, "add_wrap");
    exp2(4, S_AC, 16'h00FE, "sub_wrap");
    exp2(5, S_PC, 16'h0008, "blt_taken");
    exp2(7, S_PC, 16'h000A, "bge_not_taken");
    exp2(8, S_PC, 16'h000B, "bgt_not_taken");
    exp2(9, S_AC, 16'h0007, "after_branches");
    tick(12);

    // Delay slot, and a jump sitting in the delay slot.
    reset = 1'b0;
    load_nops();
    rom[0]     = 16'h0033;                 // LD $33
    rom[4]     = 16'hFC10;                 // BRA $10
    rom[5]     = 16'h0011;                 // LD $11 (slot)
    rom['h10]  = 16'h0044;                 // LD $44
    rom['h11]  = 16'hFC20;                 // BRA $20
    rom['h12]  = 16'hFC30;                 // BRA $30 (slot)
    rom['h20]  = 16'h0055;                 // LD $55
    rom['h30]  = 16'h0066;                 // LD $66
    do_reset();
    exp2(6, S_PC, 16'h0010, "bra_target");
    exp1(7, S_AC, 16'h0011, "slot_exec_db1");
    exp1(7, D0 + S_AC, 16'h0033, "slot_squash_db0");
    exp2(7, S_PC, 16'h0011, "pc_after_target");
    exp2(8, S_AC, 16'h0044, "target_exec");
    exp1(10, S_PC, 16'h0030, "second_target_db1");
    exp1(10, D0 + S_PC, 16'h0021, "seq_db0");
    exp2(11, S_AC, 16'h0055, "first_target_once");
    exp1(12, S_AC, 16'h0066, "second_target_db1_ac");
    exp1(12, D0 + S_AC, 16'h0055, "nop_db0_ac");
    tick(15);

    // RAM addressing, X increment, store/load forwarding, address truncation.
    reset = 1'b0;
    load_nops();
    rom[0] = 16'h1480;                     // LD $80 -> Y
    rom[1] = 16'h10FF;                     // LD $FF -> X
    rom[2] = 16'hCCAA;                     // ST $AA [Y,X]
    rom[3] = 16'h1D00;                     // LD [Y,X++] -> OUT
    rom[4] = 16'hC05B;                     // ST $5B [$5B]
    rom[5] = 16'h015B;                     // LD [$5B]
    rom[6] = 16'h01FF;                     // LD [$FF]
    do_reset();
    exp2(2, S_Y, 16'h0080, "y_load");
    exp2(3, S_X, 16'h00FF, "x_load");
    exp2(4, S_OUT, 16'h0000, "out_before");
    exp2(5, S_OUT, 16'h00AA, "out_yx_ram");
    exp2(5, S_X, 16'h0000, "x_inc_wrap");
    exp2(5, S_XOUT, 16'h0000, "xout_no_hsync");
    exp2(7, S_AC, 16'h005B, "st_then_ld");
    exp2(8, S_AC, 16'h00AA, "ram_trunc");
    tick(10);

    // XOUT capture on hsync rising edge, and the IN synchroniser.
    reset = 1'b0;
    load_nops();
    rom[0] = 16'h0037;                     // LD $37
    rom[1] = 16'h1800;                     // LD $00 -> OUT
    rom[2] = 16'h1840;                     // LD $40 -> OUT
    rom[3] = 16'h0012;                     // LD $12
    rom[4] = 16'h1840;                     // LD $40 -> OUT
    rom[5] = 16'h0300;                     // LD IN
    do_reset();
    exp2(3, S_XOUT, 16'h0000, "xout_out00");
    exp2(4, S_OUT, 16'h0040, "out_40");
    exp2(4, S_XOUT, 16'h0037, "xout_edge");
    exp2(5, S_AC, 16'h0012, "ac_12");
    exp2(6, S_XOUT, 16'h0037, "xout_no_edge");
    exp2(7, S_AC, 16'h00C3, "in_port");
    tick(10);

    // Same program without and with a 5-cycle run stall.
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b0;
      load_nops();
      rom[0] = 16'h0003;                   // LD $03
      rom[1] = 16'h8004;                   // ADD $04
      rom[2] = 16'h1021;                   // LD $21 -> X
      rom[3] = 16'h1442;                   // LD $42 -> Y
      rom[4] = 16'h60FF;                   // XOR $FF
      rom[5] = 16'h1C09;                   // LD $09 -> OUT, X++
      rom[6] = 16'h4001;                   // OR $01
      rom[7] = 16'h200F;                   // AND $0F
      do_reset();
      if (pass == 0) begin
        exp2(9, S_AC, 16'h0009, "ref_ac");
        exp2(9, S_X, 16'h0022, "ref_x");
        exp2(9, S_Y, 16'h0042, "ref_y");
        exp2(9, S_PC, 16'h0009, "ref_pc");
        exp2(9, S_OUT, 16'h0009, "ref_out");
        tick(12);
      end else begin
        exp2(5, S_PC, 16'h0003, "stall_pc");
        exp2(7, S_AC, 16'h0007, "stall_ac");
        exp2(8, S_PC, 16'h0003, "stall_pc_end");
        exp2(9, S_PC, 16'h0004, "resume_pc");
        exp2(14, S_AC, 16'h0009, "stall_ac_final");
        exp2(14, S_X, 16'h0022, "stall_x_final");
        exp2(14, S_Y, 16'h0042, "stall_y_final");
        exp2(14, S_PC, 16'h0009, "stall_pc_final");
        exp2(14, S_OUT, 16'h0009, "stall_out_final");
        tick(3);
        run = 1'b0;
        tick(5);
        run = 1'b1;
        tick(10);
      end
    end

    // Reset asserted while a taken jump executes.
    reset = 1'b0;
    load_nops();
    rom[0]    = 16'h0001;                  // LD $01
    rom[1]    = 16'hFC20;                  // BRA $20
    rom[2]    = 16'h0002;                  // LD $02 (slot)
    rom['h20] = 16'h0003;                  // LD $03
    do_reset();
    exp2(2, S_AC, 16'h0001, "pre_reset_ac");
    exp2(2, S_PC, 16'h0002, "pre_reset_pc");
    tick(2);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    base  = cyc;
    exp2(0, S_PC, 16'h0000, "midbranch_rst_pc");
    exp2(0, S_AC, 16'h0000, "midbranch_rst_ac");
    exp2(1, S_PC, 16'h0001, "restart_pc1");
    exp2(3, S_PC, 16'h0020, "rejump_pc");
    wait_pc("rejump_wait_db1", S_PC, 16'h0020, 10);
    tick(6);

    tick(2);
    $display("%0d/%0d checks passed", n_pass + n_dpass, n_checks + n_dchecks);
    $finish;
  end

endmodule
